uart_transmitter: RTL and testbench
===================================

Name: uart_transmitter

Overview:
- Serial transmit engine for the micro UART controller. Sits directly downstream of the register set.
- Pops bytes from the first-word-fall-through TX FIFO and serialises each one onto tx_o as start, data, optional parity and stop bits.
- Takes line format and baud divisor from the LCR and DLL/DLM outputs, and reports transmitter-idle status back through tsr_empty_o, which feeds LSR[6].

Parameters:
- OVERSAMPLE, 16, baud ticks per bit period (16550-compatible; a bit period lasts OVERSAMPLE*baud_div clocks).

Ports:
- clk_i  input  1  reference clock
- rst_n_i  input  1  reset; asynchronous assert, active-low
- tx_fifo_rd_data_i  input  8  head of the TX FIFO; valid whenever tx_fifo_rd_empty_i=0
- tx_fifo_rd_empty_i  input  1  TX FIFO empty
- tx_fifo_rd_en_o  output  1  one-cycle pop strobe to the TX FIFO
- word_len_i  input  2  LCR[1:0]; data bits = 5 + word_len_i
- stp_bits_i  input  1  LCR[2]; 0 = 1 stop bit, 1 = 2 stop bits (1.5 when word_len_i=00)
- parity_en_i  input  1  LCR[3]; parity bit enable
- even_parity_sel_i  input  1  LCR[4]; 1 = even parity, 0 = odd parity
- baud_div_i  input  16  {DLM, DLL} divisor
- tx_o  output  1  serial line; idles high
- tsr_empty_o  output  1  1 when no frame is in progress

Behaviour:
- Reset: all flops clear asynchronously. tx_o=1, tsr_empty_o=1, tx_fifo_rd_en_o=0, state=IDLE, all counters 0. Reset asserted mid-frame forces tx_o=1 immediately and abandons the frame. No partial bits are sent after release.
- All outputs are registered.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - Starts a frame when tx_fifo_rd_empty_i=0 AND baud_div_i!=0. In that cycle:
    - pulse tx_fifo_rd_en_o=1 for exactly one clock;
    - capture tx_fifo_rd_data_i into the shift register;
    - latch word_len, stp_bits, parity_en, even_parity_sel and baud_div for the whole frame;
    - go to START.
  - tx_o=0 and tsr_empty_o=0 from the next clock.
  - With baud_div_i=0 the block stays in IDLE with tx_o=1 and never pops.
- Bit timing:
  - A 16-bit divider counts latched_div-1 down to 0 and emits one tick per wrap.
  - A 4-bit tick counter ends a bit after OVERSAMPLE ticks, i.e. exactly 16*D clocks per bit.
  - Counters restart at every frame start.
- START: one bit period of 0, then go to DATA.
- DATA:
  - Sends the shift register LSB-first, 5+word_len bits.
  - The bit counter wraps at the latched length. Data bits above the length are ignored and never sent.
  - Exits to PARITY if parity is enabled, otherwise to STOP.
- PARITY:
  - Parity is computed over the transmitted bits only, never over the masked upper bits.
  - Even mode: tx_o = XOR(bits), so total ones including parity is even.
  - Odd mode: tx_o = XNOR(bits).
- STOP:
  - tx_o=1 for 16*D clocks (1 stop), 32*D clocks (2 stop), or 24*D clocks (1.5 stop: stp_bits=1 with word_len=00).
  - At the end of the last stop clock, go to IDLE; tsr_empty_o=1 from the next clock.
- Back-to-back frames: IDLE lasts exactly one clock when the FIFO is non-empty. The inter-frame gap is one clock of tx_o=1 with tsr_empty_o=1 for that clock.
- Config or divisor changes mid-frame have no effect until the next frame start.
- A FIFO going empty mid-frame has no effect; the captured byte completes.
- tx_fifo_rd_en_o is never asserted while tx_fifo_rd_empty_i=1 and never asserted outside IDLE.
- Frame length in clocks = 16*D*(1 + 5 + wl + parity_en) + stop clocks.

Test Plan:
- Reset/idle: assert rst_n_i mid-START with D=2 -> tx_o=1, tsr_empty_o=1 immediately; tx_fifo_rd_en_o stays 0 while the FIFO is empty.
- 8N1 with D=1, byte 0x55 -> one rd_en pulse; tx_o: 16 clk low, then 1,0,1,0,1,0,1,0 at 16 clk each, then 16 clk high; tsr_empty_o low for 160 clk.
- 7E1 with D=3, byte 0xB5 -> 7 data bits 1,0,1,0,1,1,0; even parity bit=0 (four ones); bit 7 never sent; frame = 10*48 = 480 clk. Odd mode on the same byte -> parity bit=1.
- 5-bit with stp_bits=1, D=1, byte 0x1F -> stop high for 24 clk; frame = 6*16+24 = 120 clk. 6-bit with stp_bits=1 -> 32-clk stop.
- Back-to-back: 3 bytes queued, 8N1, D=1 -> exactly 3 rd_en pulses, 161 clocks apart; one-clock gap high between frames; tsr_empty_o high only during the gaps and after the last frame.
- Mid-frame change: switch baud_div_i 1->4 and word_len_i 11->00 during the DATA of frame 1 -> frame 1 is unchanged (160 clk, 8 bits); frame 2 uses 5 bits at 64 clk/bit; baud_div_i=0 with data queued -> no pop, tx_o=1.

Source files
------------

// File: rtl/uart_transmitter.sv
// UART serial transmit engine: pops bytes from a FWFT TX FIFO and sends start, data (LSB first), optional parity and stop bits.
// Latency: frame starts one clock after a byte is seen in IDLE; the pop strobe (registered) and the start bit begin on that same clock.
// Backpressure: pops only from IDLE with a non-empty FIFO and a non-zero divisor; line format and divisor are frozen for the whole frame.
module uart_transmitter #(
  parameter int OVERSAMPLE = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [7:0]  tx_fifo_rd_data_i,
  input  logic        tx_fifo_rd_empty_i,
  output logic        tx_fifo_rd_en_o,
  input  logic [1:0]  word_len_i,
  input  logic        stp_bits_i,
  input  logic        parity_en_i,
  input  logic        even_parity_sel_i,
  input  logic [15:0] baud_div_i,
  output logic        tx_o,
  output logic        tsr_empty_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]  r_state;
  logic [7:0]  r_shift;
  logic [2:0]  r_nbits_last;
  logic [2:0]  r_bit_cnt;
  logic        r_par_en;
  logic        r_par_bit;
  logic [15:0] r_div;
  logic [15:0] r_div_cnt;
  logic [3:0]  r_tick_cnt;
  logic [5:0]  r_stop_cnt;
  logic [5:0]  r_stop_last;
  logic        r_tx;
  logic        r_tsr_empty;
  logic        r_rd_en;

  logic        w_start;
  logic        w_tick;
  logic        w_bit_end;
  logic        w_stop_end;
  logic [7:0]  w_mask;
  logic        w_par_bit;
  logic [5:0]  w_stop_last;

  // Frame start decision and bit-timing strobes.
  assign w_start    = (r_state == S_IDLE) && !tx_fifo_rd_empty_i && (baud_div_i != 16'd0);
  assign w_tick     = (r_div_cnt == 16'd0);
  assign w_bit_end  = w_tick && (r_tick_cnt == 4'(OVERSAMPLE - 1));
  assign w_stop_end = w_tick && (r_stop_cnt == r_stop_last);

  // Word mask, parity over the transmitted bits only, and stop length in ticks for the incoming frame.
  always_comb begin
    w_mask = 8'hFF;
    case (word_len_i)
      2'b00:   w_mask = 8'h1F;
      2'b01:   w_mask = 8'h3F;
      2'b10:   w_mask = 8'h7F;
      default: w_mask = 8'hFF;
    endcase
    w_par_bit = even_parity_sel_i ? (^(tx_fifo_rd_data_i & w_mask))
                                  : ~(^(tx_fifo_rd_data_i & w_mask));
    if (!stp_bits_i) begin
      w_stop_last = 6'(OVERSAMPLE - 1);
    end else if (word_len_i == 2'b00) begin
      w_stop_last = 6'((OVERSAMPLE * 3) / 2 - 1);
    end else begin
      w_stop_last = 6'(2 * OVERSAMPLE - 1);
    end
  end

  // Baud divider and oversample tick counter; both restart at every frame start.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_div_cnt  <= 16'd0;
      r_tick_cnt <= 4'd0;
    end else if (w_start) begin
      r_div_cnt  <= baud_div_i - 16'd1;
      r_tick_cnt <= 4'd0;
    end else if (r_state != S_IDLE) begin
      if (w_tick) begin
        r_div_cnt  <= r_div - 16'd1;
        r_tick_cnt <= w_bit_end ? 4'd0 : r_tick_cnt + 4'd1;
      end else begin
        r_div_cnt  <= r_div_cnt - 16'd1;
      end
    end
  end

  // Frame sequencer: latches the frame configuration and drives the registered line, status and pop strobe.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= S_IDLE;
      r_shift      <= 8'd0;
      r_nbits_last <= 3'd0;
      r_bit_cnt    <= 3'd0;
      r_par_en     <= 1'b0;
      r_par_bit    <= 1'b0;
      r_div        <= 16'd0;
      r_stop_cnt   <= 6'd0;
      r_stop_last  <= 6'd0;
      r_tx         <= 1'b1;
      r_tsr_empty  <= 1'b1;
      r_rd_en      <= 1'b0;
    end else begin
      r_rd_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx        <= 1'b1;
          r_tsr_empty <= 1'b1;
          if (w_start) begin
            r_rd_en      <= 1'b1;
            r_shift      <= tx_fifo_rd_data_i;
            r_nbits_last <= 3'd4 + 3'(word_len_i);
            r_par_en     <= parity_en_i;
            r_par_bit    <= w_par_bit;
            r_div        <= baud_div_i;
            r_stop_last  <= w_stop_last;
            r_bit_cnt    <= 3'd0;
            r_stop_cnt   <= 6'd0;
            r_tx         <= 1'b0;
            r_tsr_empty  <= 1'b0;
            r_state      <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_tx      <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_cnt <= 3'd0;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_bit_cnt == r_nbits_last) begin
              if (r_par_en) begin
                r_tx    <= r_par_bit;
                r_state <= S_PARITY;
              end else begin
                r_tx       <= 1'b1;
                r_stop_cnt <= 6'd0;
                r_state    <= S_STOP;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_tx      <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
            end
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_tx       <= 1'b1;
            r_stop_cnt <= 6'd0;
            r_state    <= S_STOP;
          end
        end
        S_STOP: begin
          r_tx <= 1'b1;
          if (w_stop_end) begin
            r_tsr_empty <= 1'b1;
            r_state     <= S_IDLE;
          end else if (w_tick) begin
            r_stop_cnt <= r_stop_cnt + 6'd1;
          end
        end
        default: begin
          r_tx        <= 1'b1;
          r_tsr_empty <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_o            = r_tx;
  assign tsr_empty_o     = r_tsr_empty;
  assign tx_fifo_rd_en_o = r_rd_en;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: FIFO model, frame scoreboard and serial-line monitor.
module tb_uart_transmitter;

  typedef struct {
    logic [7:0] data;
    int         wl;
    bit         stp;
    bit         pen;
    bit         even;
    int         d;
  } frame_t;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [7:0]  tx_fifo_rd_data_i = 8'h00;
  logic        tx_fifo_rd_empty_i = 1'b1;
  logic        tx_fifo_rd_en_o;
  logic [1:0]  word_len_i = 2'b11;
  logic        stp_bits_i = 1'b0;
  logic        parity_en_i = 1'b0;
  logic        even_parity_sel_i = 1'b0;
  logic [15:0] baud_div_i = 16'd2;
  logic        tx_o;
  logic        tsr_empty_o;

  int         pass_cnt = 0;
  int         total_cnt = 0;
  int         cyc = 0;
  int         pops = 0;
  int         pop_cyc[$];
  logic [7:0] fifo_q[$];
  frame_t     exp_q[$];
  bit         cur[$];
  bit         last_wave[$];
  int         last_len = 0;
  int         frames_seen = 0;
  int         exp_pushed = 0;
  bit         mon_en = 1'b0;
  bit         idle_bad = 1'b0;

  uart_transmitter #(.OVERSAMPLE(16)) dut (
    .clk_i              (clk_i),
    .rst_n_i            (rst_n_i),
    .tx_fifo_rd_data_i  (tx_fifo_rd_data_i),
    .tx_fifo_rd_empty_i (tx_fifo_rd_empty_i),
    .tx_fifo_rd_en_o    (tx_fifo_rd_en_o),
    .word_len_i         (word_len_i),
    .stp_bits_i         (stp_bits_i),
    .parity_en_i        (parity_en_i),
    .even_parity_sel_i  (even_parity_sel_i),
    .baud_div_i         (baud_div_i),
    .tx_o               (tx_o),
    .tsr_empty_o        (tsr_empty_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: line level at clock index idx of a frame, from the frame rules.
  function automatic bit exp_bit(frame_t f, int idx);
    int bp   = 16 * f.d;
    int n    = 5 + f.wl;
    int sym  = idx / bp;
    int ones = 0;
    if (sym == 0) return 1'b0;
    if (sym <= n) return f.data[sym - 1];
    if (f.pen && sym == n + 1) begin
      for (int i = 0; i < n; i++) ones += int'(f.data[i]);
      return f.even ? bit'(ones % 2) : bit'(1 - ones % 2);
    end
    return 1'b1;
  endfunction

  function automatic int exp_len(frame_t f);
    int stop_ticks = f.stp ? ((f.wl == 0) ? 24 : 32) : 16;
    return 16 * f.d * (1 + 5 + f.wl + int'(f.pen)) + stop_ticks * f.d;
  endfunction

  // FIFO model: pops on the strobe, presents the head otherwise.
  initial begin
    forever begin
      @(negedge clk_i);
      if (tx_fifo_rd_en_o === 1'b1) begin
        pops++;
        pop_cyc.push_back(cyc);
        check("pop_from_nonempty", int'(fifo_q.size() > 0), 1);
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      end
      tx_fifo_rd_empty_i = (fifo_q.size() == 0);
      tx_fifo_rd_data_i  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    end
  end

  // Monitor: captures the line while a frame is in progress and scores it when tsr_empty returns.
  initial begin
    frame_t e;
    int el;
    int mism;
    forever begin
      @(negedge clk_i);
      if (!rst_n_i || !mon_en) begin
        cur.delete();
      end else if (!tsr_empty_o) begin
        cur.push_back(tx_o);
      end else begin
        if (tx_o !== 1'b1) idle_bad = 1'b1;
        if (cur.size() > 0) begin
          frames_seen++;
          check("frame_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            el = exp_len(e);
            check($sformatf("frame_len[%02h]", e.data), cur.size(), el);
            mism = -1;
            for (int i = 0; i < cur.size(); i++) begin
              if (i >= el || cur[i] != exp_bit(e, i)) begin
                mism = i;
                break;
              end
            end
            check($sformatf("frame_first_bad_clk[%02h]", e.data), mism, -1);
          end
          last_len  = cur.size();
          last_wave = cur;
          cur.delete();
        end
      end
    end
  end

  task automatic set_cfg(input int wl, input bit stp, input bit pen, input bit even, input int d);
    word_len_i        = 2'(wl);
    stp_bits_i        = stp;
    parity_en_i       = pen;
    even_parity_sel_i = even;
    baud_div_i        = 16'(d);
  endtask

  task automatic push_frame(input logic [7:0] data);
    frame_t f;
    f.data = data;
    f.wl   = int'(word_len_i);
    f.stp  = stp_bits_i;
    f.pen  = parity_en_i;
    f.even = even_parity_sel_i;
    f.d    = int'(baud_div_i);
    exp_q.push_back(f);
    exp_pushed++;
    fifo_q.push_back(data);
  endtask

  task automatic wait_idle(input string name, input int maxc);
    bit done = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk_i);
      if (exp_q.size() == 0 && fifo_q.size() == 0 && tsr_empty_o === 1'b1) begin
        done = 1'b1;
        break;
      end
    end
    check({"done_in_budget_", name}, int'(done), 1);
  endtask

  task automatic wait_busy(input int maxc);
    bit seen = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk_i);
      if (tsr_empty_o === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    check("frame_started", int'(seen), 1);
  endtask

  initial begin
    int p0;
    int gap;
    logic [7:0] b;

    // Reset state.
    repeat (3) @(negedge clk_i);
    check("rst_tx", int'(tx_o), 1);
    check("rst_tsr_empty", int'(tsr_empty_o), 1);
    check("rst_rd_en", int'(tx_fifo_rd_en_o), 0);
    rst_n_i = 1'b1;

    // Reset asserted mid-START with D=2 abandons the frame at once.
    set_cfg(3, 0, 0, 0, 2);
    fifo_q.push_back(8'hA5);
    wait_busy(50);
    repeat (5) @(negedge clk_i);
    check("midstart_tx_low", int'(tx_o), 0);
    #2 rst_n_i = 1'b0;
    #1;
    check("async_rst_tx", int'(tx_o), 1);
    check("async_rst_tsr_empty", int'(tsr_empty_o), 1);
    repeat (3) @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (40) @(negedge clk_i);
    check("post_rst_pops", pops, 1);
    check("post_rst_tx_idle", int'(tx_o), 1);
    check("post_rst_tsr_empty", int'(tsr_empty_o), 1);
    mon_en = 1'b1;

    // 8N1, D=1, 0x55.
    set_cfg(3, 0, 0, 0, 1);
    p0 = pops;
    push_frame(8'h55);
    wait_idle("8n1", 400);
    check("8n1_len", last_len, 160);
    check("8n1_pops", pops - p0, 1);

    // 7E1, D=3, 0xB5: parity 0, bit 7 never sent.
    set_cfg(2, 0, 1, 1, 3);
    push_frame(8'hB5);
    wait_idle("7e1", 1000);
    check("7e1_len", last_len, 480);
    check("7e1_parity", int'(last_wave[8 * 48 + 24]), 0);
    check("7e1_stop_not_bit7", int'(last_wave[9 * 48 + 24]), 1);
    // 7O1 on the same byte: parity 1.
    set_cfg(2, 0, 1, 0, 3);
    push_frame(8'hB5);
    wait_idle("7o1", 1000);
    check("7o1_parity", int'(last_wave[8 * 48 + 24]), 1);

    // 5-bit with 1.5 stop, then 6-bit with 2 stop.
    set_cfg(0, 1, 0, 0, 1);
    push_frame(8'h1F);
    wait_idle("5n15", 400);
    check("5n15_len", last_len, 120);
    set_cfg(1, 1, 0, 0, 1);
    push_frame(8'h2A);
    wait_idle("6n2", 400);
    check("6n2_len", last_len, 144);

    // Back-to-back: three queued bytes, 8N1, D=1.
    set_cfg(3, 0, 0, 0, 1);
    p0 = pop_cyc.size();
    for (int i = 0; i < 3; i++) push_frame(8'($urandom));
    wait_idle("b2b", 1000);
    check("b2b_pops", pop_cyc.size() - p0, 3);
    for (int i = 1; i < 3; i++) begin
      gap = (pop_cyc.size() > p0 + i) ? pop_cyc[p0 + i] - pop_cyc[p0 + i - 1] : -1;
      check("b2b_pop_spacing", gap, 161);
    end

    // Mid-frame divisor/length change only affects the next frame.
    set_cfg(3, 0, 0, 0, 1);
    push_frame(8'hC3);
    wait_busy(50);
    repeat (40) @(negedge clk_i);
    set_cfg(0, 0, 0, 0, 4);
    push_frame(8'h9C);
    wait_idle("midchg", 1000);
    check("midchg_frame2_len", last_len, 448);

    // Randomized frames.
    for (int k = 0; k < 12; k++) begin
      set_cfg(int'($urandom_range(3, 0)), 1'($urandom), 1'($urandom), 1'($urandom),
              int'($urandom_range(3, 1)));
      b = 8'($urandom);
      push_frame(b);
      if ($urandom_range(1, 0) == 1) push_frame(8'($urandom));
      wait_idle("rand", 3000);
    end

    // Zero divisor: no pop, line stays idle.
    baud_div_i = 16'd0;
    p0 = pops;
    fifo_q.push_back(8'h77);
    repeat (100) @(negedge clk_i);
    check("div0_no_pop", pops - p0, 0);
    check("div0_tx_idle", int'(tx_o), 1);
    check("div0_tsr_empty", int'(tsr_empty_o), 1);

    check("idle_line_high", int'(idle_bad), 0);
    check("frames_seen", frames_seen, exp_pushed);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
